// File: rtl/key_filter.sv
// Push-button debouncer with press/release pulses and an LED mode selector.
// Key_in is asynchronous and active-low. It passes through a two-flop synchroniser.
// A four-state filter then requires CNT_MAX+1 stable samples before it
// accepts a level change. All outputs are registered.

module key_filter #(
  parameter int unsigned CNT_MAX = 999_999
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Key_in,
  output logic       Key_press,
  output logic       Key_release,
  output logic       Key_state,
  output logic [1:0] Led_mode
);

  // Counter is wide enough to hold CNT_MAX; guard the degenerate CNT_MAX=0 case.
  localparam int unsigned CntW = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CNT_MAX);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StFiltDn = 2'd1;
  localparam logic [1:0] StDown   = 2'd2;
  localparam logic [1:0] StFiltUp = 2'd3;

  logic            sync1_q, sync2_q;
  logic            key_s;
  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            level_q, level_d;
  logic [1:0]      mode_q, mode_d;

  assign key_s = sync2_q;

  // Two-flop synchroniser; idles high (released) out of reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= Key_in;
      sync2_q <= sync1_q;
    end
  end

  // Filter next-state: any bounce sends the filter back to the settled state with cnt cleared.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    level_d   = level_q;
    mode_d    = mode_q;
    unique case (state_q)
      StIdle: begin
        if (!key_s) begin
          state_d = StFiltDn;
          cnt_d   = '0;
        end
      end
      StFiltDn: begin
        if (key_s) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q < CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          state_d = StDown;
          cnt_d   = '0;
          press_d = 1'b1;
          level_d = 1'b1;
          mode_d  = mode_q + 2'd1;
        end
      end
      StDown: begin
        if (key_s) begin
          state_d = StFiltUp;
          cnt_d   = '0;
        end
      end
      StFiltUp: begin
        if (!key_s) begin
          state_d = StDown;
          cnt_d   = '0;
        end else if (cnt_q < CntMax) begin
          cnt_d = cnt_q + CntW'(1);
        end else begin
          state_d   = StIdle;
          cnt_d     = '0;
          release_d = 1'b1;
          level_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Filter state, counter and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      level_q   <= 1'b0;
      mode_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      level_q   <= level_d;
      mode_q    <= mode_d;
    end
  end

  assign Key_press   = press_q;
  assign Key_release = release_q;
  assign Key_state   = level_q;
  assign Led_mode    = mode_q;

endmodule

// File: tb/tb_key_filter.sv
// Testbench for key_filter with CNT_MAX=9. Directed scenarios are followed by a randomised run.
// A run-length reference model checks every cycle.

module tb_key_filter;

  localparam int unsigned CntMaxTb = 9;

  logic       clk;
  logic       reset_n;
  logic       key_in;
  logic       key_press;
  logic       key_release;
  logic       key_state;
  logic [1:0] led_mode;

  key_filter #(.CNT_MAX(CntMaxTb)) dut (
    .Clk        (clk),
    .Reset_n    (reset_n),
    .Key_in     (key_in),
    .Key_press  (key_press),
    .Key_release(key_release),
    .Key_state  (key_state),
    .Led_mode   (led_mode)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model. A level change is accepted once the synchronised key has disagreed
  // with the current debounced level on CNT_MAX+2 consecutive edges: the first edge enters
  // the filter, the next CNT_MAX edges count, and the last edge commits the change.
  logic       h0, h1;
  logic       m_level;
  int         m_run;
  logic       m_press, m_rel;
  logic [1:0] m_mode;
  int         press_cnt = 0;
  int         rel_cnt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input logic k, input logic rn);
    logic ks;
    key_in  = k;
    reset_n = rn;
    @(posedge clk);
    #1;
    if (!rn) begin
      h0 = 1'b1; h1 = 1'b1;
      m_level = 1'b0; m_run = 0;
      m_press = 1'b0; m_rel = 1'b0; m_mode = 2'd0;
    end else begin
      ks = h1;
      h1 = h0;
      h0 = k;
      m_press = 1'b0;
      m_rel   = 1'b0;
      if ((~ks) != m_level) m_run++;
      else m_run = 0;
      if (m_run == CntMaxTb + 2) begin
        m_level = ~m_level;
        m_run   = 0;
        if (m_level) begin
          m_press = 1'b1;
          m_mode  = m_mode + 2'd1;
        end else begin
          m_rel = 1'b1;
        end
      end
    end
    chk("key_press", 32'(key_press), 32'(m_press));
    chk("key_release", 32'(key_release), 32'(m_rel));
    chk("key_state", 32'(key_state), 32'(m_level));
    chk("led_mode", 32'(led_mode), 32'(m_mode));
    if (key_press === 1'b1) press_cnt++;
    if (key_release === 1'b1) rel_cnt++;
  endtask

  int         lat;
  int         p0, r0;
  logic [1:0] wrap_modes [4];
  int         wrap_idx;
  int         run_len;
  logic       lvl;

  initial begin
    key_in  = 1'b1;
    reset_n = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("reset_state", 32'(key_state), 32'd0);
    chk("reset_mode", 32'(led_mode), 32'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1);

    // Clean press: pulse follows the 13th edge that samples the key low.
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b1);
      if (key_press === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("press_latency", 32'(lat), 32'd13);
    chk("press_mode", 32'(led_mode), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);

    // Clean release, which does not change the mode.
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b1, 1'b1);
      if (key_release === 1'b1) begin
        lat = i;
        break;
      end
    end
    chk("release_latency", 32'(lat), 32'd13);
    chk("release_mode", 32'(led_mode), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);

    // Bounce: two short low bursts are rejected.
    p0 = press_cnt;
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
    chk("bounce_no_press", 32'(press_cnt - p0), 32'd0);

    // Mode wrap from reset: the sequence is 1,2,3,0.
    step(1'b1, 1'b0);
    p0 = press_cnt;
    r0 = rel_cnt;
    wrap_idx = 0;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) begin
        step(1'b0, 1'b1);
        if (key_press === 1'b1 && wrap_idx < 4) begin
          wrap_modes[wrap_idx] = led_mode;
          wrap_idx++;
        end
      end
      for (int i = 0; i < 16; i++) step(1'b1, 1'b1);
    end
    chk("wrap_presses", 32'(press_cnt - p0), 32'd4);
    chk("wrap_releases", 32'(rel_cnt - r0), 32'd4);
    chk("wrap_mode0", 32'(wrap_modes[0]), 32'd1);
    chk("wrap_mode1", 32'(wrap_modes[1]), 32'd2);
    chk("wrap_mode2", 32'(wrap_modes[2]), 32'd3);
    chk("wrap_mode3", 32'(wrap_modes[3]), 32'd0);

    // Reset mid-filter: cnt reaches 5 after the 8th low edge, and reset hits on the 9th.
    p0 = press_cnt;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("midreset_state", 32'(key_state), 32'd0);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, 1'b1);
      if (key_press === 1'b1 && lat == 0) lat = i;
    end
    chk("midreset_latency", 32'(lat), 32'd13);
    chk("midreset_one_press", 32'(press_cnt - p0), 32'd1);

    // Reset while in DOWN: no release is emitted at any point.
    r0 = rel_cnt;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    chk("downreset_state", 32'(key_state), 32'd0);
    chk("downreset_mode", 32'(led_mode), 32'd0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1);
    chk("downreset_no_release", 32'(rel_cnt - r0), 32'd0);

    // Randomised runs of mixed length with occasional reset.
    lvl = 1'b1;
    for (int n = 0; n < 300; n++) begin
      run_len = int'($urandom_range(1, 14));
      lvl = ~lvl;
      for (int i = 0; i < run_len; i++) begin
        step(lvl, ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1);
      end
    end
    for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 SHALL provide parameter CNT_MAX, default 999_999, meaning the debounce count limit: the press/release must be stable for CNT_MAX+1 cycles (20 ms at 50 MHz).
REQ-002 SHALL provide port Clk, input, 1, meaning the system clock (50 MHz); the block has one clock and all logic is on its rising edge.
REQ-003 SHALL provide port Reset_n, input, 1, meaning the synchronous, active-low reset, sampled on the rising edge of Clk.
REQ-004 SHALL provide port Key_in, input, 1, meaning the raw asynchronous push-button, active-low (0 = pressed).
REQ-005 SHALL provide port Key_press, output, 1, meaning a one-cycle pulse on each debounced press.
REQ-006 SHALL provide port Key_release, output, 1, meaning a one-cycle pulse on each debounced release.
REQ-007 SHALL provide port Key_state, output, 1, meaning the debounced level (1 = held).
REQ-008 SHALL provide port Led_mode, output, 2, meaning the flash-mode select fed to the downstream LED flasher.

Function
REQ-009 SHALL synchronise Key_in through two flip-flops (sync1, sync2), with sync2 as the only FSM input (key_s).
REQ-010 SHALL implement the states IDLE, FILT_DN, DOWN and FILT_UP, encoded as registered state.
REQ-011 SHALL use a debounce counter ceil(log2(CNT_MAX+1)) bits wide (20 bits at default) that never exceeds CNT_MAX.
REQ-012 SHALL, in IDLE with key_s=0, go to FILT_DN with cnt←0; otherwise it stays in IDLE.
REQ-013 SHALL, in FILT_DN, handle key_s as follows:
- key_s=1: go to IDLE with cnt←0 (bounce rejected, no pulse).
- key_s=0 and cnt<CNT_MAX: cnt←cnt+1.
- key_s=0 and cnt==CNT_MAX: go to DOWN, Key_press←1 for one cycle, Key_state←1.
REQ-014 SHALL, in DOWN with key_s=1, go to FILT_UP with cnt←0; otherwise it stays in DOWN.
REQ-015 SHALL, in FILT_UP, handle key_s as follows:
- key_s=0: go to DOWN with cnt←0 (no pulse).
- key_s=1 and cnt<CNT_MAX: cnt←cnt+1.
- key_s=1 and cnt==CNT_MAX: go to IDLE, Key_release←1 for one cycle, Key_state←0.
REQ-016 SHALL register all outputs, with Key_press and Key_release low in every cycle other than the transition cycle.
REQ-017 SHALL give a press latency such that, when Key_in is held low from rising edge e1 onward (e1 being the first edge sampling it low), Key_press is high exactly during the cycle after edge e(CNT_MAX+4); release latency is symmetric.
REQ-018 SHALL increment Led_mode on the same edge that asserts Key_press, wrapping 3→0, with no change on release.
REQ-019 SHALL never assert Key_press and Key_release in the same cycle, and never assert either on two consecutive cycles.
REQ-020 SHALL restart the filter from 0 on any bounce shorter than CNT_MAX+1 stable cycles, with no partial credit carried over.
REQ-021 SHALL hold Key_state constant in FILT_DN (value 0) and FILT_UP (value 1).

Reset
REQ-022 SHALL, while Reset_n=0 at a rising edge, set state←IDLE, cnt←0, sync1/sync2←1, Key_press←0, Key_release←0, Key_state←0 and Led_mode←0.
REQ-023 SHALL let reset abort any in-progress filtering without emitting a pulse, including a reset asserted while in DOWN (no Key_release is emitted).
REQ-024 SHALL, if Key_in is held low across reset release, restart filtering from IDLE and produce exactly one Key_press after the full latency of REQ-017.
REQ-025 SHALL leave a power-up state free of any X on outputs after the first reset edge.

Verification (CNT_MAX=9 in bench, 20 ns clock)
REQ-026 SHALL cover a clean press: Key_in 1→0 held -> Key_press high one cycle after the 13th edge sampling low, Key_state=1, Led_mode 0→1.
REQ-027 SHALL cover a clean release after REQ-026: Key_in 0→1 held -> Key_release high one cycle after the 13th edge sampling high, Key_state=0, Led_mode stays 1.
REQ-028 SHALL cover bounce: Key_in low 6 cycles, high 2, low 6, high held -> no Key_press, Key_state stays 0, Led_mode stays 0.
REQ-029 SHALL cover wrap: 4 clean press/release pairs -> Led_mode sequence 1,2,3,0 with exactly 4 Key_press and 4 Key_release pulses.
REQ-030 SHALL cover reset mid-filter: Reset_n low one edge while cnt=5 in FILT_DN -> all outputs 0, no pulse; Key_in still low -> a single Key_press at full latency after reset release.
REQ-031 SHALL cover reset in DOWN: Reset_n low for 3 cycles while held -> Key_state=0, Led_mode=0, no Key_release at any point.
